// File: rtl/jtcps2_obj_pkg.sv
// Shared types and constants for the CPS2 object-table DMA.
// State encoding and end-of-list marker position live here.
package jtcps2_obj_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StRd   = 3'd2,
    StWr   = 3'd3,
    StRel  = 3'd4
  } dma_st_e;

  localparam int unsigned CntW       = 11;
  localparam logic [1:0]  EndWordIdx = 2'd1;
  localparam int unsigned EndBit     = 15;

  // End-of-list: the second word of an object entry carries bit 15 set.
  function automatic logic is_end_marker(input logic [CntW-1:0] cnt, input logic [15:0] word);
    return (cnt[1:0] == EndWordIdx) && word[EndBit];
  endfunction

endpackage

// File: rtl/jtcps2_objdma_edge.sv
// Falling-edge detector for the active-low vertical blank signal.
module jtcps2_objdma_edge (
  input  logic clk,
  input  logic rstn,
  input  logic lvbl,
  output logic fall
);

  logic lvbl_q;

  // Resetting the history low keeps a held-low LVBL from looking like an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvbl_q <= 1'b0;
    end else begin
      lvbl_q <= lvbl;
    end
  end

  assign fall = lvbl_q & ~lvbl;

endmodule

// File: rtl/jtcps2_objdma.sv
// Copies the object table from shared RAM into the line-engine buffer once per frame.
// Optional JTCPS2_OBJEND_EN: stop early at the end-of-list marker word.
module jtcps2_objdma
  import jtcps2_obj_pkg::*;
#(
  parameter int unsigned WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        LVBL,
  input  logic        obank,
  input  logic [15:0] oram_base,
  output logic        busreq,
  input  logic        busack,
  output logic [16:0] ram_addr,
  output logic        ram_cs,
  input  logic [15:0] ram_data,
  input  logic        ram_ok,
  output logic [11:0] buf_addr,
  output logic [15:0] buf_data,
  output logic        buf_we,
  output logic        disp_page,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

`ifdef JTCPS2_OBJEND_EN
  localparam logic ObjEndEn = 1'b1;
`else
  localparam logic ObjEndEn = 1'b0;
`endif

  localparam logic [11:0] WordsLim = 12'(WORDS);

  dma_st_e         st;
  logic [CntW-1:0] cnt;
  logic [15:0]     word;
  logic            page;
  logic            cs_q;
  logic            fall;
  logic [11:0]     cnt_nx;
  logic            end_mark;
  logic            last_word;
  logic            unused_base;

  jtcps2_objdma_edge u_edge (
    .clk  (clk),
    .rstn (rstn),
    .lvbl (LVBL),
    .fall (fall)
  );

  assign cnt_nx    = {1'b0, cnt} + 12'd1;
  assign end_mark  = ObjEndEn & is_end_marker(cnt, word);
  assign last_word = end_mark | (cnt_nx >= WordsLim);

  // Losing the bus must cut the RAM access in the same cycle, not one later.
  assign ram_cs    = cs_q & busack;
  assign ram_addr  = {oram_base[8], obank, 4'd0, cnt};
  assign buf_addr  = {page, cnt};
  assign buf_data  = word;
  assign disp_page = ~page;
  assign busy      = (st != StIdle);

  assign unused_base = ^{oram_base[15:9], oram_base[7:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= StIdle;
      busreq  <= 1'b0;
      cs_q    <= 1'b0;
      buf_we  <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      cnt     <= '0;
      word    <= '0;
      page    <= 1'b0;
    end else begin
      buf_we  <= 1'b0;
      done    <= 1'b0;
      overrun <= fall && (st != StIdle);
      case (st)
        StIdle: begin
          if (fall) begin
            busreq <= 1'b1;
            cnt    <= '0;
            st     <= StReq;
          end
        end
        StReq: begin
          if (busack) begin
            cs_q <= 1'b1;
            st   <= StRd;
          end
        end
        StRd: begin
          if (!busack) begin
            cs_q <= 1'b0;
            st   <= StReq;
          end else if (ram_ok) begin
            word   <= ram_data;
            cs_q   <= 1'b0;
            buf_we <= 1'b1;
            st     <= StWr;
          end
        end
        StWr: begin
          // The buffer write is local, so it completes even if the bus is lost here.
          cnt <= cnt + 1'b1;
          if (last_word) begin
            busreq <= 1'b0;
            st     <= StRel;
          end else if (!busack) begin
            st <= StReq;
          end else begin
            cs_q <= 1'b1;
            st   <= StRd;
          end
        end
        StRel: begin
          if (!busack) begin
            page <= ~page;
            done <= 1'b1;
            st   <= StIdle;
          end
        end
        default: st <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcps2_objdma.sv
// Scoreboard bench for jtcps2_objdma: random frames, bus loss, overrun and mid-transfer reset.
module tb_jtcps2_objdma;

  localparam int unsigned WORDS = 8;

`ifdef JTCPS2_OBJEND_EN
  localparam bit ObjEnd = 1'b1;
`else
  localparam bit ObjEnd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        LVBL = 1'b1;
  logic        obank = 1'b0;
  logic [15:0] oram_base = 16'd0;
  logic        busack = 1'b0;
  logic [15:0] ram_data = 16'd0;
  logic        ram_ok = 1'b0;
  logic        busreq, ram_cs, buf_we, disp_page, busy, done, overrun;
  logic [16:0] ram_addr;
  logic [11:0] buf_addr;
  logic [15:0] buf_data;

  always #5 clk = ~clk;

  jtcps2_objdma #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .LVBL      (LVBL),
    .obank     (obank),
    .oram_base (oram_base),
    .busreq    (busreq),
    .busack    (busack),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_data  (ram_data),
    .ram_ok    (ram_ok),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .buf_we    (buf_we),
    .disp_page (disp_page),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] seed = 16'h1234;
  bit          end_mode = 1'b0;
  int          lat = 1;
  int          drop_after = -1;
  bit          drop_done = 1'b0;
  bit          chk_cs_low = 1'b0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          ovr_cnt = 0;
  int          exp_n = 0;
  int          exp_ovr = 0;
  bit          first_seen = 1'b0;
  logic [16:0] first_addr = '0;
  logic [16:0] exp_first = '0;
  logic        pg = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM contents: a fixed scramble of the address; end mode plants a marker at word 5 only.
  function automatic logic [15:0] mem_word(input logic [16:0] a);
    logic [31:0] t;
    logic [15:0] w;
    t = {15'd0, a} * 32'h0000_9e37;
    w = t[15:0] ^ seed;
    if (end_mode) begin
      w[15] = 1'b0;
      if (a[10:0] == 11'd5) w = 16'h8000;
    end
    return w;
  endfunction

  // Bus arbiter: grant two cycles after request, optionally revoke after N writes.
  initial begin
    int req_cyc;
    int hold;
    req_cyc = 0;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busreq) begin
        req_cyc = 0;
        busack = 1'b0;
      end else if (hold > 0) begin
        hold--;
        busack = 1'b0;
        req_cyc = 0;
      end else if (drop_after >= 0 && !drop_done && wr_cnt == drop_after && busack) begin
        busack = 1'b0;
        hold = 3;
        drop_done = 1'b1;
        chk_cs_low = 1'b1;
        req_cyc = 0;
      end else begin
        req_cyc++;
        if (req_cyc >= 2) busack = 1'b1;
      end
    end
  end

  // RAM: answers after lat cycles of continuous chip select.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (ram_cs) begin
        n++;
        ram_data = mem_word(ram_addr);
        ram_ok = (n >= lat);
      end else begin
        n = 0;
        ram_ok = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every buffer write and tallies pulses.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (ram_cs && !first_seen) begin
          first_seen = 1'b1;
          first_addr = ram_addr;
        end
        if (buf_we) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                     buf_addr, buf_data);
          end else begin
            e = exp_q.pop_front();
            check("buf_addr", {20'd0, buf_addr}, {20'd0, e.addr});
            check("buf_data", {16'd0, buf_data}, {16'd0, e.data});
          end
        end
        if (done) done_cnt++;
        if (overrun) ovr_cnt++;
        if (chk_cs_low) begin
          chk_cs_low = 1'b0;
          check("ram_cs_drop", {31'd0, ram_cs}, 32'd0);
        end
      end
    end
  end

  task automatic start_frame(input logic bank, input logic [15:0] base, input int ramlat,
                             input bit endm, input int drop);
    wr_t         e;
    logic [16:0] a;
    logic [15:0] d;
    obank = bank;
    oram_base = base;
    lat = ramlat;
    end_mode = endm;
    drop_after = drop;
    drop_done = 1'b0;
    seed = 16'($urandom);
    wr_cnt = 0;
    done_cnt = 0;
    ovr_cnt = 0;
    exp_ovr = 0;
    first_seen = 1'b0;
    exp_n = 0;
    for (int i = 0; i < int'(WORDS); i++) begin
      a = {base[8], bank, 4'd0, 11'(i)};
      d = mem_word(a);
      e.addr = {pg, 11'(i)};
      e.data = d;
      exp_q.push_back(e);
      exp_n++;
      if (ObjEnd && (i % 4) == 1 && d[15]) break;
    end
    exp_first = {base[8], bank, 15'd0};
    @(posedge clk);
    #1 LVBL = 1'b1;
    @(posedge clk);
    #1 LVBL = 1'b0;
  endtask

  task automatic wait_rd(input string name);
    int t;
    t = 0;
    while (!first_seen && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({name, " rd_seen"}, {31'd0, first_seen}, 32'd1);
  endtask

  task automatic finish_frame(input string name);
    int   t;
    logic exp_dp;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    pg = ~pg;
    exp_dp = ~pg;
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " writes"}, wr_cnt, exp_n);
    check({name, " leftover"}, exp_q.size(), 0);
    exp_q.delete();
    check({name, " first_ram_addr"}, {15'd0, first_addr}, {15'd0, exp_first});
    check({name, " disp_page"}, {31'd0, disp_page}, {31'd0, exp_dp});
    check({name, " overrun_pulses"}, ovr_cnt, exp_ovr);
    check({name, " busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1;
    check("rst busreq", {31'd0, busreq}, 32'd0);
    check("rst ram_cs", {31'd0, ram_cs}, 32'd0);
    check("rst buf_we", {31'd0, buf_we}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst overrun", {31'd0, overrun}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst disp_page", {31'd0, disp_page}, 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    start_frame(1'b1, 16'h0100, 1, 1'b0, -1);
    finish_frame("basic");
    check("basic first_addr_abs", {15'd0, first_addr}, 32'h0001_8000);

    for (int r = 0; r < 5; r++) begin
      start_frame(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 3), 1'b0, -1);
      finish_frame("rand");
    end

    start_frame(1'b0, 16'h0000, 1, 1'b0, 3);
    finish_frame("busloss");
    check("busloss applied", {31'd0, drop_done}, 32'd1);
    drop_after = -1;

    start_frame(1'b0, 16'h0100, 1, 1'b1, -1);
    finish_frame("endmark");
    end_mode = 1'b0;

    start_frame(1'b1, 16'h0000, 2, 1'b0, -1);
    wait_rd("overrun");
    @(posedge clk);
    #1 LVBL = 1'b1;
    @(posedge clk);
    #1 LVBL = 1'b0;
    exp_ovr = 1;
    finish_frame("overrun");

    start_frame(1'b0, 16'h0100, 3, 1'b0, -1);
    wait_rd("midreset");
    #1 rstn = 1'b0;
    #1;
    check("midreset busreq", {31'd0, busreq}, 32'd0);
    check("midreset ram_cs", {31'd0, ram_cs}, 32'd0);
    exp_q.delete();
    pg = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset disp_page", {31'd0, disp_page}, 32'd1);
    check("midreset busreq_after", {31'd0, busreq}, 32'd0);

    start_frame(1'($urandom_range(0, 1)), 16'($urandom), 2, 1'b0, -1);
    finish_frame("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
